// File: rtl/bcd_down_timer_pkg.sv
// bcd_timer_pkg: shared state type, BCD limit and nibble clamp for the BCD down timer
package bcd_timer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    localparam logic [3:0] BCD_MAX = 4'd9;
    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return nibble > BCD_MAX ? BCD_MAX : nibble;
    endfunction
endpackage

// File: rtl/bcd_down_timer_if.sv
// bcd_down_timer_if: control/status bundle between a controller and the BCD down timer
interface bcd_down_timer_if #(parameter int DIGITS = 2);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  start;
    logic                  pause;
    logic [4*DIGITS-1:0]   count;
    logic                  running;
    logic                  done;
    logic                  zero;
    modport master (output load, load_val, start, pause, input count, running, done, zero);
    modport slave  (input load, load_val, start, pause, output count, running, done, zero);
endinterface

// File: rtl/bcd_down_timer_digit.sv
// bcd_digit_down: one registered BCD decade that decrements when its borrow input is set
module bcd_digit_down
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       dec,
    input  logic       borrow_in,
    output logic [3:0] q,
    output logic       borrow_out,
    output logic       is_zero
);
    assign is_zero    = q == 4'd0;
    assign borrow_out = borrow_in & is_zero;
    always_ff @(posedge clk or negedge clr)
        if (!clr) q <= '0;
        else if (ld) q <= ld_val;
        else if (dec && borrow_in) q <= is_zero ? BCD_MAX : q - 4'd1;
endmodule

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: loadable multi-decade BCD countdown with pause, done pulse and optional auto-reload
module bcd_down_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input logic            clk,
    input logic            clr,
    bcd_down_timer_if.slave bus
);
    localparam int W = 4 * DIGITS;
    state_t          state, state_d;
    logic [W-1:0]    preset, load_clamped, ld_vec;
    logic [DIGITS:0] borrow;
    logic [DIGITS-1:0] dz;
    logic            dec, reload, done_d, term;
    always_comb begin
        load_clamped = '0;
        for (int k = 0; k < DIGITS; k++) load_clamped[4*k +: 4] = bcd_clamp(bus.load_val[4*k +: 4]);
    end
    assign ld_vec    = bus.load ? load_clamped : preset;
    assign borrow[0] = 1'b1;
    // the borrow ripples out of the top decade only when every decade is zero
    assign term      = borrow[DIGITS];
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_down u_digit (
                .clk       (clk),
                .clr       (clr),
                .ld        (bus.load | reload),
                .ld_val    (ld_vec[4*g +: 4]),
                .dec       (dec),
                .borrow_in (borrow[g]),
                .q         (bus.count[4*g +: 4]),
                .borrow_out(borrow[g+1]),
                .is_zero   (dz[g])
            );
        end
    endgenerate
    assign bus.zero    = &dz;
    assign bus.running = state == RUN;
    always_comb begin
        state_d = state;
        dec     = 1'b0;
        reload  = 1'b0;
        done_d  = 1'b0;
        if (bus.load) state_d = IDLE;
        else
            unique case (state)
                IDLE: state_d = (bus.start && !term) ? RUN : IDLE;
                RUN: begin
                    if (term) begin
                        done_d  = 1'b1;
                        reload  = AUTO_RELOAD && preset != '0;
                        state_d = reload ? RUN : IDLE;
                    end else if (bus.pause) state_d = HOLD;
                    else dec = 1'b1;
                end
                HOLD: state_d = bus.start ? RUN : HOLD;
                default: state_d = IDLE;
            endcase
    end
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            state    <= IDLE;
            preset   <= '0;
            bus.done <= 1'b0;
        end else begin
            state    <= state_d;
            bus.done <= done_d;
            if (bus.load) preset <= load_clamped;
        end
endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: scoreboard bench for two timer configurations (2 digits one-shot, 3 digits auto-reload)
module tb_bcd_down_timer;
    logic clk = 1'b0;
    logic clr = 1'b1;
    logic ld = 1'b0, st = 1'b0, pa = 1'b0;
    logic [11:0] lv = '0;
    always #5 clk = ~clk;
    bcd_down_timer_if #(.DIGITS(2)) b0 ();
    bcd_down_timer_if #(.DIGITS(3)) b1 ();
    assign b0.load = ld;  assign b0.load_val = lv[7:0];  assign b0.start = st;  assign b0.pause = pa;
    assign b1.load = ld;  assign b1.load_val = lv;       assign b1.start = st;  assign b1.pause = pa;
    bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(1'b0)) dut0 (.clk(clk), .clr(clr), .bus(b0));
    bcd_down_timer #(.DIGITS(3), .AUTO_RELOAD(1'b1)) dut1 (.clk(clk), .clr(clr), .bus(b1));
    typedef struct packed {
        logic [31:0] count;
        logic        running;
        logic        done;
        logic        zero;
    } exp_t;
    exp_t q0[$], q1[$];
    int vectors = 0, miscompares = 0;
    // reference: count held as a plain decimal integer; mode 0=idle 1=run 2=hold
    int m_cnt[2], m_pre[2], m_mode[2];
    bit m_done[2];
    function automatic int nd(input int i);
        return i == 0 ? 2 : 3;
    endfunction
    function automatic int dec_val(input logic [11:0] v, input int n);
        int r = 0, p = 1, nib;
        for (int k = 0; k < n; k++) begin
            nib = int'(v[4*k +: 4]);
            r += (nib > 9 ? 9 : nib) * p;
            p *= 10;
        end
        return r;
    endfunction
    function automatic logic [31:0] to_bcd(input int v, input int n);
        logic [31:0] r = '0;
        int x = v;
        for (int k = 0; k < n; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x /= 10;
        end
        return r;
    endfunction
    function automatic exp_t expect_of(input int i);
        exp_t e;
        e.count   = to_bcd(m_cnt[i], nd(i));
        e.running = m_mode[i] == 1;
        e.done    = m_done[i];
        e.zero    = m_cnt[i] == 0;
        return e;
    endfunction
    task automatic model(input int i, input logic l, input logic [11:0] v, input logic s, input logic p);
        bit ar = i == 1;
        m_done[i] = 1'b0;
        if (l) begin
            m_cnt[i]  = dec_val(v, nd(i));
            m_pre[i]  = m_cnt[i];
            m_mode[i] = 0;
        end else if (m_mode[i] == 0) begin
            if (s && m_cnt[i] != 0) m_mode[i] = 1;
        end else if (m_mode[i] == 1) begin
            if (m_cnt[i] == 0) begin
                m_done[i] = 1'b1;
                if (ar && m_pre[i] != 0) m_cnt[i] = m_pre[i];
                else m_mode[i] = 0;
            end else if (p) m_mode[i] = 2;
            else m_cnt[i] = m_cnt[i] - 1;
        end else if (s) m_mode[i] = 1;
        if (i == 0) q0.push_back(expect_of(0));
        else q1.push_back(expect_of(1));
    endtask
    task automatic check(input string name, input exp_t e, input logic [31:0] c, input logic r, input logic d, input logic z);
        vectors++;
        if (c !== e.count || r !== e.running || d !== e.done || z !== e.zero) begin
            miscompares++;
            $display("FAIL %s t=%0t: got count=%h running=%b done=%b zero=%b, want count=%h running=%b done=%b zero=%b",
                     name, $time, c, r, d, z, e.count, e.running, e.done, e.zero);
        end
    endtask
    task automatic cycle(input logic l, input logic [11:0] v, input logic s, input logic p);
        @(negedge clk);
        ld = l; lv = v; st = s; pa = p;
        model(0, l, v, s, p);
        model(1, l, v, s, p);
    endtask
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_mode[i] = 0; m_done[i] = 1'b0;
        end
    endtask
    task automatic async_reset(input string name);
        @(posedge clk);
        #2 clr = 1'b0;
        model_reset();
        #1;
        check({name, "_d2"}, expect_of(0), 32'(b0.count), b0.running, b0.done, b0.zero);
        check({name, "_d3"}, expect_of(1), 32'(b1.count), b1.running, b1.done, b1.zero);
        #1 clr = 1'b1;
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("d2_oneshot", e, 32'(b0.count), b0.running, b0.done, b0.zero);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("d3_reload", e, 32'(b1.count), b1.running, b1.done, b1.zero);
            end
        end
    end
    initial begin
        model_reset();
        #1 clr = 1'b0;
        #2;
        check("por_d2", expect_of(0), 32'(b0.count), b0.running, b0.done, b0.zero);
        check("por_d3", expect_of(1), 32'(b1.count), b1.running, b1.done, b1.zero);
        #1 clr = 1'b1;
        cycle(1, 12'h012, 0, 0); cycle(0, 0, 1, 0);
        repeat (16) cycle(0, 0, 0, 0);
        cycle(1, 12'h100, 0, 0); cycle(0, 0, 1, 0);
        repeat (5) cycle(0, 0, 0, 0);
        cycle(1, 12'h005, 0, 0); cycle(0, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        repeat (6) cycle(0, 0, 0, 0);
        cycle(1, 12'h000, 0, 0); cycle(0, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 0);
        cycle(1, 12'hFAF, 0, 0); cycle(0, 0, 0, 0);
        cycle(1, 12'h045, 1, 0);
        repeat (2) cycle(0, 0, 0, 0);
        cycle(1, 12'h003, 0, 0); cycle(0, 0, 1, 0);
        repeat (10) cycle(0, 0, 0, 0);
        cycle(1, 12'h000, 0, 0);
        repeat (2) cycle(0, 0, 0, 0);
        cycle(1, 12'h037, 0, 0); cycle(0, 0, 1, 0);
        async_reset("mid_run_reset");
        repeat (4) cycle(0, 0, 0, 0);
        repeat (1500) begin
            logic [11:0] v;
            v = ($urandom % 4 == 0) ? 12'(32'($urandom)) : 12'($urandom_range(0, 20));
            if ($urandom % 200 == 0) async_reset("rand_reset");
            else cycle(($urandom % 16) == 0, v, ($urandom % 4) == 0, ($urandom % 8) == 0);
        end
        cycle(0, 0, 0, 0);
        @(posedge clk);
        #3;
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
